// File: rtl/id_queue_stage.sv
// id_queue_stage: RV32I decode stage with an input instruction FIFO and a registered output bundle.
// Defining ID_RV32M_EN adds decode of the RV32M multiply/divide instructions.
`ifndef OpCodeLen
`define OpCodeLen 6
`define NOP    6'd0
`define LUI    6'd1
`define AUIPC  6'd2
`define JAL    6'd3
`define JALR   6'd4
`define BEQ    6'd5
`define BNE    6'd6
`define BLT    6'd7
`define BGE    6'd8
`define BLTU   6'd9
`define BGEU   6'd10
`define LB     6'd11
`define LH     6'd12
`define LW     6'd13
`define LBU    6'd14
`define LHU    6'd15
`define SB     6'd16
`define SH     6'd17
`define SW     6'd18
`define ADDI   6'd19
`define SLTI   6'd20
`define SLTIU  6'd21
`define XORI   6'd22
`define ORI    6'd23
`define ANDI   6'd24
`define SLLI   6'd25
`define SRLI   6'd26
`define SRAI   6'd27
`define ADD    6'd28
`define SUB    6'd29
`define SLL    6'd30
`define SLT    6'd31
`define SLTU   6'd32
`define XOR    6'd33
`define SRL    6'd34
`define SRA    6'd35
`define OR     6'd36
`define AND    6'd37
`define MUL    6'd38
`define MULH   6'd39
`define MULHSU 6'd40
`define MULHU  6'd41
`define DIV    6'd42
`define DIVU   6'd43
`define REM    6'd44
`define REMU   6'd45
`endif

module id_queue_stage #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned XLEN   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rdy,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_W-1:0]     in_pc,
  input  logic [31:0]           in_inst,
  output logic [4:0]            reg1_addr_o,
  output logic [4:0]            reg2_addr_o,
  input  logic [XLEN-1:0]       reg1_data_i,
  input  logic [XLEN-1:0]       reg2_data_i,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [`OpCodeLen-1:0] op,
  output logic [4:0]            rd,
  output logic [XLEN-1:0]       reg1,
  output logic [XLEN-1:0]       reg2,
  output logic [XLEN-1:0]       imm,
  output logic [ADDR_W-1:0]     pc_o,
  output logic                  illegal
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [31:0]       inst_mem [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic              head_valid, push, pop;

  assign head_valid = (count_q != '0);
  assign in_ready   = (count_q < CntW'(DEPTH));
  assign push       = rdy && !flush && in_valid && in_ready;
  assign pop        = rdy && !flush && head_valid && (!out_valid || out_ready);

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= in_pc;
      inst_mem[wr_ptr_q] <= in_inst;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (rdy) begin
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
        if (push && !pop)      count_q <= count_q + CntW'(1);
        else if (pop && !push) count_q <= count_q - CntW'(1);
      end
    end
  end

  // Head decode
  logic [31:0]       hi;
  logic [ADDR_W-1:0] hpc, hpc4;
  logic [6:0]        opc, f7;
  logic [2:0]        f3;
  logic [20:0]       j_raw;
  logic [12:0]       b_raw;
  logic [XLEN-1:0]   imm_i, imm_s, imm_u, j_tgt, b_tgt;

  assign hi    = inst_mem[rd_ptr_q];
  assign hpc   = pc_mem[rd_ptr_q];
  assign hpc4  = hpc + ADDR_W'(4);
  assign opc   = hi[6:0];
  assign f3    = hi[14:12];
  assign f7    = hi[31:25];
  assign j_raw = {hi[31], hi[19:12], hi[20], hi[30:21], 1'b0};
  assign b_raw = {hi[31], hi[7], hi[30:25], hi[11:8], 1'b0};
  assign imm_i = XLEN'($signed(hi[31:20]));
  assign imm_s = XLEN'($signed({hi[31:25], hi[11:7]}));
  assign imm_u = XLEN'({hi[31:12], 12'b0});
  assign j_tgt = XLEN'(hpc + ADDR_W'($signed(j_raw)));
  assign b_tgt = XLEN'(hpc + ADDR_W'($signed(b_raw)));

  logic [`OpCodeLen-1:0] dec_op;
  logic [4:0]            dec_rd;
  logic [XLEN-1:0]       dec_imm, dec_reg1, dec_reg2;
  logic                  use_rs1, use_rs2, r1_pc, r1_pc4, r2_pc4, ill;

  always_comb begin
    dec_op  = `NOP;
    dec_rd  = hi[11:7];
    dec_imm = '0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    r1_pc   = 1'b0;
    r1_pc4  = 1'b0;
    r2_pc4  = 1'b0;
    ill     = 1'b0;
    case (opc)
      7'b0110111: begin dec_op = `LUI; dec_imm = imm_u; end
      7'b0010111: begin dec_op = `AUIPC; dec_imm = imm_u; r1_pc = 1'b1; end
      7'b1101111: begin dec_op = `JAL; dec_imm = j_tgt; r1_pc4 = 1'b1; end
      7'b1100111: begin
        dec_op = `JALR; dec_imm = imm_i; use_rs1 = 1'b1; r2_pc4 = 1'b1;
        ill = (f3 != 3'b000);
      end
      7'b1100011: begin
        dec_rd = '0; dec_imm = b_tgt; use_rs1 = 1'b1; use_rs2 = 1'b1;
        case (f3)
          3'b000:  dec_op = `BEQ;
          3'b001:  dec_op = `BNE;
          3'b100:  dec_op = `BLT;
          3'b101:  dec_op = `BGE;
          3'b110:  dec_op = `BLTU;
          3'b111:  dec_op = `BGEU;
          default: ill = 1'b1;
        endcase
      end
      7'b0000011: begin
        dec_imm = imm_i; use_rs1 = 1'b1;
        case (f3)
          3'b000:  dec_op = `LB;
          3'b001:  dec_op = `LH;
          3'b010:  dec_op = `LW;
          3'b100:  dec_op = `LBU;
          3'b101:  dec_op = `LHU;
          default: ill = 1'b1;
        endcase
      end
      7'b0100011: begin
        dec_rd = '0; dec_imm = imm_s; use_rs1 = 1'b1; use_rs2 = 1'b1;
        case (f3)
          3'b000:  dec_op = `SB;
          3'b001:  dec_op = `SH;
          3'b010:  dec_op = `SW;
          default: ill = 1'b1;
        endcase
      end
      7'b0010011: begin
        dec_imm = imm_i; use_rs1 = 1'b1;
        case (f3)
          3'b000: dec_op = `ADDI;
          3'b010: dec_op = `SLTI;
          3'b011: dec_op = `SLTIU;
          3'b100: dec_op = `XORI;
          3'b110: dec_op = `ORI;
          3'b111: dec_op = `ANDI;
          3'b001: begin dec_op = `SLLI; dec_imm = XLEN'(hi[24:20]); ill = (f7 != 7'b0000000); end
          default: begin
            dec_imm = XLEN'(hi[24:20]);
            if (f7 == 7'b0000000)      dec_op = `SRLI;
            else if (f7 == 7'b0100000) dec_op = `SRAI;
            else                       ill = 1'b1;
          end
        endcase
      end
      7'b0110011: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        if (f7 == 7'b0000000) begin
          case (f3)
            3'b000:  dec_op = `ADD;
            3'b001:  dec_op = `SLL;
            3'b010:  dec_op = `SLT;
            3'b011:  dec_op = `SLTU;
            3'b100:  dec_op = `XOR;
            3'b101:  dec_op = `SRL;
            3'b110:  dec_op = `OR;
            default: dec_op = `AND;
          endcase
        end else if (f7 == 7'b0100000) begin
          if (f3 == 3'b000)      dec_op = `SUB;
          else if (f3 == 3'b101) dec_op = `SRA;
          else                   ill = 1'b1;
`ifdef ID_RV32M_EN
        end else if (f7 == 7'b0000001) begin
          case (f3)
            3'b000:  dec_op = `MUL;
            3'b001:  dec_op = `MULH;
            3'b010:  dec_op = `MULHSU;
            3'b011:  dec_op = `MULHU;
            3'b100:  dec_op = `DIV;
            3'b101:  dec_op = `DIVU;
            3'b110:  dec_op = `REM;
            default: dec_op = `REMU;
          endcase
`endif
        end else begin
          ill = 1'b1;
        end
      end
      default: ill = 1'b1;
    endcase
    // Undecodable instructions carry no operands so nothing downstream acts on them.
    if (ill) begin
      dec_op  = `NOP;
      dec_rd  = '0;
      dec_imm = '0;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      r1_pc   = 1'b0;
      r1_pc4  = 1'b0;
      r2_pc4  = 1'b0;
    end
  end

  assign reg1_addr_o = (head_valid && use_rs1) ? hi[19:15] : 5'd0;
  assign reg2_addr_o = (head_valid && use_rs2) ? hi[24:20] : 5'd0;
  assign dec_reg1 = use_rs1 ? reg1_data_i : r1_pc ? XLEN'(hpc) : r1_pc4 ? XLEN'(hpc4) : '0;
  assign dec_reg2 = use_rs2 ? reg2_data_i : r2_pc4 ? XLEN'(hpc4) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      op        <= `NOP;
      rd        <= '0;
      reg1      <= '0;
      reg2      <= '0;
      imm       <= '0;
      pc_o      <= '0;
      illegal   <= 1'b0;
    end else if (rdy) begin
      if (flush) begin
        out_valid <= 1'b0;
        op        <= `NOP;
        illegal   <= 1'b0;
      end else if (pop) begin
        out_valid <= 1'b1;
        op        <= dec_op;
        rd        <= dec_rd;
        reg1      <= dec_reg1;
        reg2      <= dec_reg2;
        imm       <= dec_imm;
        pc_o      <= hpc;
        illegal   <= ill;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        op        <= `NOP;
        illegal   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_id_queue_stage.sv
// Directed, table-driven bench for id_queue_stage: decode vectors plus queueing, flush,
// freeze and reset sequences.
module tb_id_queue_stage;
  localparam logic [5:0] OpNop = 6'd0,  OpLui = 6'd1,   OpAuipc = 6'd2, OpJal = 6'd3;
  localparam logic [5:0] OpJalr = 6'd4, OpBeq = 6'd5,   OpSw = 6'd18,   OpAddi = 6'd19;
  localparam logic [5:0] OpSrai = 6'd27, OpSub = 6'd29, OpMul = 6'd38;

  logic        clk = 1'b0, rst_n = 1'b0, rdy = 1'b1, flush = 1'b0;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, illegal;
  logic [31:0] in_pc = '0, in_inst = '0, reg1_data, reg2_data, reg1, reg2, imm, pc_o;
  logic [4:0]  reg1_addr, reg2_addr, rd;
  logic [5:0]  op;
  logic [31:0] rf [32];

  int n_vec = 0, n_miss = 0;

  always #5 clk = ~clk;

  assign reg1_data = rf[reg1_addr];
  assign reg2_data = rf[reg2_addr];

  id_queue_stage #(.DEPTH(4), .ADDR_W(32), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .reg1_addr_o(reg1_addr), .reg2_addr_o(reg2_addr),
    .reg1_data_i(reg1_data), .reg2_data_i(reg2_data),
    .out_valid(out_valid), .out_ready(out_ready), .op(op), .rd(rd),
    .reg1(reg1), .reg2(reg2), .imm(imm), .pc_o(pc_o), .illegal(illegal)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  ra1, ra2;
    logic [5:0]  op;
    logic [4:0]  rd;
    logic [31:0] reg1, reg2, imm;
    logic        ill;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  function automatic logic [31:0] addi_k(input int k);
    logic [11:0] i12;
    logic [4:0]  r;
    i12 = 12'(k);
    r   = 5'(k);
    return {i12, 5'd0, 3'b000, r, 7'h13};
  endfunction

  // Push with out_ready low until the FIFO stops accepting; returns number accepted.
  task automatic fill(output int acc);
    acc = 0;
    out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      logic was;
      in_inst  = addi_k(acc + 1);
      in_valid = 1'b1;
      was      = in_ready;
      tick();
      if (was) acc++;
    end
    in_valid = 1'b0;
  endtask

  initial begin
    int acc;
    logic seen;

    for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'd0 : (32'h1000_0000 | 32'(i));
    rf[1] = 32'd7;

    vecs.push_back('{32'h100, 32'hFFF08293, 5'd1, 5'd0, OpAddi, 5'd5, 32'd7, 32'd0,
                     32'hFFFF_FFFF, 1'b0});
    vecs.push_back('{32'h100, 32'h00208463, 5'd1, 5'd2, OpBeq, 5'd0, 32'd7, 32'h1000_0002,
                     32'h108, 1'b0});
    vecs.push_back('{32'h100, 32'h010000EF, 5'd0, 5'd0, OpJal, 5'd1, 32'h104, 32'd0,
                     32'h110, 1'b0});
`ifdef ID_RV32M_EN
    vecs.push_back('{32'h200, 32'h022081B3, 5'd1, 5'd2, OpMul, 5'd3, 32'd7, 32'h1000_0002,
                     32'd0, 1'b0});
`else
    vecs.push_back('{32'h200, 32'h022081B3, 5'd0, 5'd0, OpNop, 5'd0, 32'd0, 32'd0,
                     32'd0, 1'b1});
`endif
    vecs.push_back('{32'h204, 32'hFFFFFFFF, 5'd0, 5'd0, OpNop, 5'd0, 32'd0, 32'd0, 32'd0, 1'b1});
    vecs.push_back('{32'h208, 32'h123453B7, 5'd0, 5'd0, OpLui, 5'd7, 32'd0, 32'd0,
                     32'h1234_5000, 1'b0});
    vecs.push_back('{32'h20C, 32'h40208233, 5'd1, 5'd2, OpSub, 5'd4, 32'd7, 32'h1000_0002,
                     32'd0, 1'b0});
    vecs.push_back('{32'h210, 32'h0020A423, 5'd1, 5'd2, OpSw, 5'd0, 32'd7, 32'h1000_0002,
                     32'd8, 1'b0});
    vecs.push_back('{32'h214, 32'h4030D313, 5'd1, 5'd0, OpSrai, 5'd6, 32'd7, 32'd0,
                     32'd3, 1'b0});
    vecs.push_back('{32'h100, 32'h004100E7, 5'd2, 5'd0, OpJalr, 5'd1, 32'h1000_0002, 32'h104,
                     32'd4, 1'b0});
    vecs.push_back('{32'h100, 32'h00001097, 5'd0, 5'd0, OpAuipc, 5'd1, 32'h100, 32'd0,
                     32'h1000, 1'b0});

    // Reset state
    tick();
    check("reset_state", {out_valid, op, rd, reg1, reg2, imm, illegal, in_ready},
          {1'b0, OpNop, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1});
    rst_n = 1'b1;
    tick();
    check("empty_addr", {reg1_addr, reg2_addr}, 10'd0);

    // Decode table: push at one edge, bundle must appear on the next
    foreach (vecs[i]) begin
      in_pc    = vecs[i].pc;
      in_inst  = vecs[i].inst;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check($sformatf("addr[%0d]", i), {reg1_addr, reg2_addr}, {vecs[i].ra1, vecs[i].ra2});
      tick();
      check($sformatf("bundle[%0d]", i), {out_valid, op, rd, reg1, reg2, imm, pc_o, illegal},
            {1'b1, vecs[i].op, vecs[i].rd, vecs[i].reg1, vecs[i].reg2, vecs[i].imm,
             vecs[i].pc, vecs[i].ill});
    end
    tick();
    check("drained", out_valid, 1'b0);

    // Back-pressure: DEPTH+1 accepted, head bundle held, then released in order
    do_reset();
    fill(acc);
    check("fill_count", {acc, in_ready}, {32'd5, 1'b0});
    check("held_bundle", {out_valid, op, rd, imm}, {1'b1, OpAddi, 5'd1, 32'd1});
    out_ready = 1'b1;
    for (int j = 2; j <= 5; j++) begin
      tick();
      check($sformatf("release[%0d]", j), {out_valid, rd, imm}, {1'b1, 5'(j), 32'(j)});
    end
    tick();
    check("release_end", out_valid, 1'b0);

    // Flush with full FIFO and a simultaneous push
    do_reset();
    fill(acc);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_inst  = addi_k(9);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush", {out_valid, op, in_ready}, {1'b0, OpNop, 1'b1});
    out_ready = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("flush_no_ghost", seen, 1'b0);

    // rdy=0 freezes: no push while low, and a valid bundle is held despite out_ready
    do_reset();
    rdy      = 1'b0;
    in_valid = 1'b1;
    in_inst  = addi_k(3);
    tick();
    tick();
    in_valid = 1'b0;
    rdy      = 1'b1;
    tick();
    check("freeze_no_push", {out_valid, reg1_addr}, {1'b0, 5'd0});
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rdy = 1'b0;
    tick();
    tick();
    check("freeze_hold", {out_valid, rd, imm}, {1'b1, 5'd3, 32'd3});
    rdy = 1'b1;
    tick();
    check("unfreeze_accept", out_valid, 1'b0);

    // Asynchronous reset with three entries queued behind a held bundle
    do_reset();
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      in_inst  = addi_k(k);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async_reset", {out_valid, op, in_ready}, {1'b0, OpNop, 1'b1});
    #1;
    rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
